pkt_serializer: RTL and testbench
=================================

# pkt_serializer

Parametrised packet-to-serial converter for the USB transmit path, replacing the fixed 99-bit parallel-to-serial converter. It accepts a variable-length packet of up to MAX_W bits over a valid/ready handshake and emits it one bit per clock, in a selectable bit order. It supports back-to-back packets with no idle cycle, synchronous abort, and optional USB bit stuffing. It sits between the packet-assembly FSM and the NRZI/line driver.

## Interface
Parameters:
- MAX_W, 99: maximum packet length in bits; width of load_data.
- LEN_W, 7: width of load_len; must satisfy 2^LEN_W > MAX_W.
- MSB_FIRST, 1: 1 = transmit load_data[len-1] down to [0]; 0 = transmit [0] up to [len-1].

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_b  in  1  reset, asynchronous assert, active-low.
- load_valid  in  1  packet offered.
- load_ready  out  1  serializer can accept this cycle.
- load_data  in  MAX_W  packet bits, right-aligned (bit 0 = LSB).
- load_len  in  LEN_W  packet length in bits.
- abort  in  1  synchronous cancel of the current packet.
- bit_out  out  1  serial bit; 0 when bit_valid is low.
- bit_valid  out  1  bit_out carries a line bit this cycle.
- stuffed  out  1  the current bit is an inserted stuff bit (always 0 without BITSTUFF_EN).
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse coincident with the final line bit of a packet.

## Operation
- States: IDLE, SEND, STUFF (STUFF exists only with BITSTUFF_EN).
- Accept occurs when load_valid && load_ready at a rising edge.
  - On accept: capture load_data into the shift register and the effective length into the remaining-bit counter; clear the ones counter.
- Effective length:
  - load_len == 0: the packet is accepted and discarded; state stays IDLE, no bits, no done.
  - load_len > MAX_W: clamped to MAX_W.
- IDLE -> SEND on accept with effective length ≥ 1.
- SEND: output one data bit per cycle and decrement the remaining counter.
  - When the last data bit is output, next state is SEND (if a new packet is accepted that cycle), STUFF (if a stuff bit is owed), otherwise IDLE.
- STUFF: output bit_out=0, stuffed=1 for one cycle; data is not advanced. Then return to SEND, or leave as if the last data bit had just completed.
- load_ready = ~abort && (IDLE || (SEND && last data bit && no stuff owed)).
- done = bit_valid && final line bit of the packet, whether that bit is data or stuff.
- abort (any state) forces IDLE at the next edge: no done, remaining counter cleared. abort has priority over a simultaneous load_valid, and load_ready is low while abort is high.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, load_ready 1 (when abort is 0), bit_out 0, bit_valid 0, stuffed 0, busy 0, done 0, shift register 0, counters 0.
- Accept at edge N: the first bit is valid in the cycle following N. A packet of L bits with S stuff bits occupies exactly L+S consecutive bit_valid cycles.
- Back-to-back: an accept in the last-bit cycle makes the next packet's first bit follow with no gap; done still pulses on the old packet's last bit.
- Outputs are driven from registered state only; there is no combinational path from load_* to bit_out or bit_valid.
- Reset asserted mid-packet: all outputs return to their reset values immediately (asynchronously).

## Configuration
- BITSTUFF_EN defined:
  - A 3-bit ones counter increments on every transmitted 1 and clears on every transmitted 0 (data or stuff).
  - After the sixth consecutive 1, the next cycle is a STUFF cycle.
  - This applies across the last bit of a packet: the stuff bit is emitted before done.
  - The counter clears on accept and on abort.
- BITSTUFF_EN undefined:
  - No STUFF state and no ones counter; stuffed is tied to 0.
  - Output is exactly L bits per packet.

## Test plan
- Reset, then MSB_FIRST=1, load_len=8, load_data=8'hA5 -> bit_out 1,0,1,0,0,1,0,1 on 8 consecutive bit_valid cycles starting one cycle after accept; done on the 8th cycle; busy returns to 0.
- MSB_FIRST=0, load_len=5, data=5'b00011, second packet len=3, data=3'b101 offered continuously -> 1,1,0,0,0 then 1,0,1 with no gap; exactly two done pulses; the second accept occurs in the 5th bit cycle.
- load_len=0 and then load_len=120 with MAX_W=99 -> the first produces no bits and no done; the second produces 99 bits.
- Abort asserted on the 3rd bit cycle of a 16-bit packet while load_valid is high -> bit_valid low next cycle, no done, load_ready low during abort, then the next packet is accepted normally.
- BITSTUFF_EN: 8 bits 8'hFF, MSB_FIRST=1 -> six 1s, stuff 0 (stuffed=1), then 1,1, for 9 cycles total. Data 8'h3F -> 0,0 then six 1s, then stuff 0 with done on the stuff cycle.
- rst_b pulled low mid-packet -> outputs go to reset values asynchronously; after release, load_ready=1 and a fresh packet serializes correctly.

Source files
------------

// File: rtl/pkt_serializer_if.sv
// Packet-load and serial-line signal bundle for pkt_serializer.
// master = packet source / line consumer, slave = the serializer itself.
interface pkt_serializer_if #(
    parameter int MAX_W = 99,
    parameter int LEN_W = 7
);
    logic             load_valid;
    logic             load_ready;
    logic [MAX_W-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             abort;
    logic             bit_out;
    logic             bit_valid;
    logic             stuffed;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data, load_len, abort,
        input  load_ready, bit_out, bit_valid, stuffed, busy, done
    );

    modport slave (
        input  load_valid, load_data, load_len, abort,
        output load_ready, bit_out, bit_valid, stuffed, busy, done
    );
endinterface

// File: rtl/pkt_serializer.sv
// Variable-length packet to 1-bit serial converter; optional USB bit stuffing under BITSTUFF_EN.
// Latency: first bit one cycle after accept, L (+stuff) back-to-back line cycles per packet.
// Backpressure: load_ready only in IDLE or on the final data bit with no stuff owed; abort drops it.
module pkt_serializer #(
    parameter int MAX_W     = 99,
    parameter int LEN_W     = 7,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_b,
    pkt_serializer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1
`ifdef BITSTUFF_EN
        ,
        ST_STUFF = 2'd2
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [MAX_W-1:0] r_shift;
    logic [LEN_W-1:0] r_rem;

    logic [LEN_W-1:0] w_eff_len;
    logic [MAX_W-1:0] w_aligned;
    logic [MAX_W-1:0] w_shifted;
    logic             w_cur_bit;
    logic             w_send;
    logic             w_in_stuff;
    logic             w_last;
    logic             w_stuff_owed;
    logic             w_load_ready;
    logic             w_accept;
    logic             w_eff_nonzero;

    // Oversized lengths are clamped; a zero length is accepted and dropped.
    always_comb begin
        w_eff_len = bus.load_len;
        if (bus.load_len > LEN_W'(MAX_W)) begin
            w_eff_len = LEN_W'(MAX_W);
        end
    end

    assign w_eff_nonzero = (w_eff_len != '0);

    // MSB-first left-aligns the packet so the next bit is always at the top.
    assign w_aligned = MSB_FIRST ? (bus.load_data << (MAX_W - int'(w_eff_len)))
                                 : bus.load_data;
    assign w_shifted = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
    assign w_cur_bit = MSB_FIRST ? r_shift[MAX_W-1] : r_shift[0];

    assign w_send = (r_state == ST_SEND);
    assign w_last = w_send && (r_rem == LEN_W'(1));

`ifdef BITSTUFF_EN
    logic [2:0] r_ones;

    assign w_in_stuff   = (r_state == ST_STUFF);
    // Sixth consecutive one on the line forces a stuffed zero next cycle.
    assign w_stuff_owed = w_send && w_cur_bit && (r_ones == 3'd5);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ones <= 3'd0;
        end else if (bus.abort || w_accept || w_in_stuff) begin
            r_ones <= 3'd0;
        end else if (w_send) begin
            r_ones <= w_cur_bit ? (r_ones + 3'd1) : 3'd0;
        end
    end
`else
    assign w_in_stuff   = 1'b0;
    assign w_stuff_owed = 1'b0;
`endif

    assign w_load_ready = ~bus.abort && ((r_state == ST_IDLE) || (w_last && !w_stuff_owed));
    assign w_accept     = bus.load_valid && w_load_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_eff_nonzero) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
`ifdef BITSTUFF_EN
                if (w_stuff_owed) begin
                    w_next_state = ST_STUFF;
                end else
`endif
                if (w_last) begin
                    w_next_state = (w_accept && w_eff_nonzero) ? ST_SEND : ST_IDLE;
                end
            end
`ifdef BITSTUFF_EN
            ST_STUFF: begin
                w_next_state = (r_rem == '0) ? ST_IDLE : ST_SEND;
            end
`endif
            default: w_next_state = ST_IDLE;
        endcase
        if (bus.abort) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_shift <= '0;
            r_rem   <= '0;
        end else if (bus.abort) begin
            r_rem   <= '0;
        end else if (w_accept) begin
            r_shift <= w_aligned;
            r_rem   <= w_eff_len;
        end else if (w_send) begin
            r_shift <= w_shifted;
            r_rem   <= r_rem - LEN_W'(1);
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.bit_valid  = w_send || w_in_stuff;
    assign bus.bit_out    = w_send && w_cur_bit;
    assign bus.stuffed    = w_in_stuff;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (w_last && !w_stuff_owed) || (w_in_stuff && (r_rem == '0));
endmodule

// File: tb/tb_pkt_serializer.sv
// Directed bench for pkt_serializer: one MSB-first and one LSB-first instance.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_pkt_serializer;
    localparam int MAX_W = 99;
    localparam int LEN_W = 7;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pkt_serializer_if #(.MAX_W(MAX_W), .LEN_W(LEN_W)) ifa ();
    pkt_serializer_if #(.MAX_W(MAX_W), .LEN_W(LEN_W)) ifb ();

    pkt_serializer #(.MAX_W(MAX_W), .LEN_W(LEN_W), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (ifa.slave)
    );

    pkt_serializer #(.MAX_W(MAX_W), .LEN_W(LEN_W), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (ifb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic bv, input logic bo, input logic st, input logic dn);
        chk({tag, " a.bit_valid"}, ifa.bit_valid, bv);
        chk({tag, " a.bit_out"},   ifa.bit_out,   bo);
        chk({tag, " a.stuffed"},   ifa.stuffed,   st);
        chk({tag, " a.done"},      ifa.done,      dn);
    endtask

    task automatic chk_b(input string tag, input logic bv, input logic bo, input logic dn);
        chk({tag, " b.bit_valid"}, ifb.bit_valid, bv);
        chk({tag, " b.bit_out"},   ifb.bit_out,   bo);
        chk({tag, " b.done"},      ifb.done,      dn);
    endtask

    task automatic load_a(input logic v, input logic [LEN_W-1:0] len, input logic [MAX_W-1:0] data);
        ifa.load_valid = v;
        ifa.load_len   = len;
        ifa.load_data  = data;
    endtask

    task automatic load_b(input logic v, input logic [LEN_W-1:0] len, input logic [MAX_W-1:0] data);
        ifb.load_valid = v;
        ifb.load_len   = len;
        ifb.load_data  = data;
    endtask

    initial begin
        logic [MAX_W-1:0] d;
        logic [7:0]       b8;
        logic [7:0]       seq;
        logic [8:0]       sb;
        logic [8:0]       ss;
        int               ndone;

        load_a(1'b0, '0, '0);
        load_b(1'b0, '0, '0);
        ifa.abort = 1'b0;
        ifb.abort = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_a("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset a.busy", ifa.busy, 1'b0);
        chk("reset a.load_ready", ifa.load_ready, 1'b1);
        chk_b("reset", 1'b0, 1'b0, 1'b0);
        chk("reset b.load_ready", ifb.load_ready, 1'b1);
        rst_b = 1'b1;
        @(negedge clk);

        // MSB-first 8'hA5
        b8 = 8'hA5;
        load_a(1'b1, 7'd8, 99'hA5);
        #1 chk("t1 ready", ifa.load_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_a($sformatf("t1 bit%0d", i), 1'b1, b8[7-i], 1'b0, (i == 7));
            if (i == 0) begin
                chk("t1 busy", ifa.busy, 1'b1);
                load_a(1'b0, '0, '0);
            end
        end
        @(negedge clk);
        chk_a("t1 after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1 busy end", ifa.busy, 1'b0);

        // LSB-first back-to-back: 5'b00011 then 3'b101
        seq   = 8'b1010_0011;
        ndone = 0;
        load_b(1'b1, 7'd5, 99'b00011);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_b($sformatf("t2 bit%0d", i), 1'b1, seq[i], (i == 4) || (i == 7));
            ndone += int'(ifb.done);
            if (i == 0) begin
                load_b(1'b1, 7'd3, 99'b101);
                chk("t2 ready mid", ifb.load_ready, 1'b0);
            end
            if (i == 4) chk("t2 ready last", ifb.load_ready, 1'b1);
            if (i == 5) load_b(1'b0, '0, '0);
        end
        @(negedge clk);
        chk_b("t2 after", 1'b0, 1'b0, 1'b0);
        chk("t2 done count", ndone, 2);

        // Zero length discarded, then oversized length clamped to MAX_W
        load_a(1'b1, 7'd0, 99'h1F);
        #1 chk("t3 ready", ifa.load_ready, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_a($sformatf("t3 zero%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("t3 zero busy%0d", i), ifa.busy, 1'b0);
            load_a(1'b0, '0, '0);
        end
        d     = '0;
        d[98] = 1'b1;
        d[50] = 1'b1;
        d[49] = 1'b1;
        d[0]  = 1'b1;
        load_a(1'b1, 7'd120, d);
        for (int i = 0; i < MAX_W; i++) begin
            @(negedge clk);
            chk_a($sformatf("t3 bit%0d", i), 1'b1, d[98-i], 1'b0, (i == MAX_W - 1));
            if (i == 0) load_a(1'b0, '0, '0);
        end
        @(negedge clk);
        chk_a("t3 after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort on the 3rd bit of a 16-bit packet with load_valid held high
        load_a(1'b1, 7'd16, 99'hF0F0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk_a($sformatf("t4 bit%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 1) begin
                load_a(1'b1, 7'd4, 99'b1001);
                chk("t4 ready mid", ifa.load_ready, 1'b0);
            end
        end
        ifa.abort = 1'b1;
        #1 chk("t4 ready abort send", ifa.load_ready, 1'b0);
        @(negedge clk);
        chk_a("t4 aborted", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4 busy aborted", ifa.busy, 1'b0);
        chk("t4 ready abort idle", ifa.load_ready, 1'b0);
        @(negedge clk);
        chk_a("t4 held", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4 busy held", ifa.busy, 1'b0);
        ifa.abort = 1'b0;
        #1 chk("t4 ready release", ifa.load_ready, 1'b1);
        b8 = 8'b0000_1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_a($sformatf("t4 next%0d", i), 1'b1, b8[3-i], 1'b0, (i == 3));
            if (i == 0) load_a(1'b0, '0, '0);
        end
        @(negedge clk);
        chk_a("t4 after", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef BITSTUFF_EN
        // 8'hFF: six ones, stuffed zero, two ones
        sb = 9'b110111111;
        ss = 9'b001000000;
        load_a(1'b1, 7'd8, 99'hFF);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk_a($sformatf("t6 ff%0d", i), 1'b1, sb[i], ss[i], (i == 8));
            if (i == 0) load_a(1'b0, '0, '0);
        end
        @(negedge clk);
        chk_a("t6 ff after", 1'b0, 1'b0, 1'b0, 1'b0);

        // 8'h3F: stuff bit after the final data bit carries done
        sb = 9'b011111100;
        ss = 9'b100000000;
        load_a(1'b1, 7'd8, 99'h3F);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk_a($sformatf("t6 3f%0d", i), 1'b1, sb[i], ss[i], (i == 8));
            if (i == 0) load_a(1'b0, '0, '0);
            if (i >= 7) chk($sformatf("t6 3f ready%0d", i), ifa.load_ready, 1'b0);
        end
        @(negedge clk);
        chk_a("t6 3f after", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Asynchronous reset in the middle of a packet
        b8 = 8'hA5;
        load_a(1'b1, 7'd8, 99'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_a($sformatf("t5 bit%0d", i), 1'b1, b8[7-i], 1'b0, 1'b0);
            if (i == 0) load_a(1'b0, '0, '0);
        end
        rst_b = 1'b0;
        #1;
        chk_a("t5 in reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5 busy reset", ifa.busy, 1'b0);
        chk("t5 ready reset", ifa.load_ready, 1'b1);
        @(negedge clk);
        rst_b = 1'b1;
        b8 = 8'h3C;
        load_a(1'b1, 7'd8, 99'h3C);
        #1 chk("t5 ready release", ifa.load_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_a($sformatf("t5 fresh%0d", i), 1'b1, b8[7-i], 1'b0, (i == 7));
            if (i == 0) load_a(1'b0, '0, '0);
        end
        @(negedge clk);
        chk_a("t5 after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5 busy end", ifa.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
